// File: rtl/uart_sample_framer.sv
// uart_sample_framer
//   Captures all four calibrated ADC channels on one sample_clk rising edge
//   (optionally decimated) and streams them to uart_tx as a 15-byte frame:
//     SYNC0, SYNC1, then per channel n: {"0"+n, hi, lo}, then an XOR checksum
//     of the twelve channel bytes.
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous reset, active low
//   sample_clk  in   codec sample strobe, synchronous to clk
//   sample_in0..3 in 16-bit signed samples, channels 0..3
//   tx_busy     in   uart_tx busy flag
//   tx_start    out  one-cycle start pulse to uart_tx
//   tx_data     out  byte to transmit, held between pulses
//   frame_sent  out  one-cycle pulse once the last byte has been accepted
//   overrun     out  one-cycle pulse when a trigger is dropped (framer busy)
module uart_sample_framer #(
  parameter int unsigned DECIMATE = 1,
  parameter logic [7:0]  SYNC0    = 8'h43,
  parameter logic [7:0]  SYNC1    = 8'h48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_clk,
  input  logic [15:0] sample_in0,
  input  logic [15:0] sample_in1,
  input  logic [15:0] sample_in2,
  input  logic [15:0] sample_in3,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_sent,
  output logic        overrun
);

  localparam int unsigned DW       = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [DW-1:0]       decim_cnt_q, decim_cnt_d;
  logic [7:0]          checksum_q, checksum_d;
  logic                sc_d_q;
  logic [SAMPLE_W-1:0] snap_q [4];
  logic [SAMPLE_W-1:0] snap_d [4];
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                frame_sent_q, frame_sent_d;
  logic                overrun_q, overrun_d;

  logic                sc_rise;
  logic                trigger;
  logic [7:0]          cur_byte;

  assign sc_rise = sample_clk & ~sc_d_q;

  // Decimation: fire once every DECIMATE rising edges of sample_clk.
  always_comb begin
    decim_cnt_d = decim_cnt_q;
    trigger     = 1'b0;
    if (sc_rise) begin
      if (decim_cnt_q == DW'(DECIMATE - 1)) begin
        decim_cnt_d = '0;
        trigger     = 1'b1;
      end else begin
        decim_cnt_d = decim_cnt_q + DW'(1);
      end
    end
  end

  // Frame byte selected by byte_idx.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx_q)
      4'd0:    cur_byte = SYNC0;
      4'd1:    cur_byte = SYNC1;
      4'd2:    cur_byte = 8'h30;
      4'd3:    cur_byte = snap_q[0][15:8];
      4'd4:    cur_byte = snap_q[0][7:0];
      4'd5:    cur_byte = 8'h31;
      4'd6:    cur_byte = snap_q[1][15:8];
      4'd7:    cur_byte = snap_q[1][7:0];
      4'd8:    cur_byte = 8'h32;
      4'd9:    cur_byte = snap_q[2][15:8];
      4'd10:   cur_byte = snap_q[2][7:0];
      4'd11:   cur_byte = 8'h33;
      4'd12:   cur_byte = snap_q[3][15:8];
      4'd13:   cur_byte = snap_q[3][7:0];
      4'd14:   cur_byte = checksum_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    checksum_d   = checksum_q;
    snap_d       = snap_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_sent_d = 1'b0;
    overrun_d    = 1'b0;

    // Any trigger outside IDLE (including the final WAIT_LO cycle) is dropped.
    if (trigger && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d[0] = sample_in0;
          snap_d[1] = sample_in1;
          snap_d[2] = sample_in2;
          snap_d[3] = sample_in3;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          if ((byte_idx_q >= 4'd2) && (byte_idx_q <= 4'd13)) begin
            checksum_d = checksum_q ^ cur_byte;
          end
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_idx_q == 4'd14) begin
            byte_idx_d   = '0;
            checksum_d   = 8'h00;
            frame_sent_d = 1'b1;
            state_d      = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; sc_d resets high so a sample_clk already high is no edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      decim_cnt_q  <= '0;
      checksum_q   <= 8'h00;
      sc_d_q       <= 1'b1;
      snap_q[0]    <= '0;
      snap_q[1]    <= '0;
      snap_q[2]    <= '0;
      snap_q[3]    <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_sent_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      decim_cnt_q  <= decim_cnt_d;
      checksum_q   <= checksum_d;
      sc_d_q       <= sample_clk;
      snap_q[0]    <= snap_d[0];
      snap_q[1]    <= snap_d[1];
      snap_q[2]    <= snap_d[2];
      snap_q[3]    <= snap_d[3];
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_sent_q <= frame_sent_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_sent = frame_sent_q;
  assign overrun    = overrun_q;

endmodule
